unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Sequences one single-ported, fixed-latency unified memory shared by two requesters: the pipeline's instruction-fetch port and its MEM-stage data port.
- Grants one access at a time and runs each access for LAT cycles.
- Returns read data with a one-cycle ready pulse.
- Generates stall outputs that the pipeline control uses to freeze PC/IF_to_ID (fetch) or the whole pipeline (data).

Parameters:
LAT, 2, memory access cycles per transaction (>=1)
CNT_W, 16, width of saturating conflict counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  instruction fetch request, held until if_ready
if_addr  in  32  fetch address (PC)
if_rdata  out  32  fetched instruction, valid when if_ready
if_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data address (ALU result)
d_wdata  in  32  store data
d_rdata  out  32  load data, valid when d_ready
d_ready  out  1  one-cycle completion pulse for data
stall_if  out  1  freeze PC and IF_to_ID
stall_pipe  out  1  freeze all pipeline registers
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  32  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid in last ACCESS cycle
busy  out  1  FSM not IDLE
conflict_cnt  out  CNT_W  number of IDLE-state grants where both requests were pending; saturates at all-ones

Behaviour:
- Reset (rst=1 at an edge) forces:
  - state IDLE, last_owner=IF, cnt=0, conflict_cnt=0
  - mem_en, mem_we, if_ready, d_ready all 0
  - if_rdata, d_rdata, mem_addr, mem_wdata all 0
  - Reset mid-transaction aborts the access; no ready pulse is issued.
- States: IDLE, ACCESS, DONE.
- IDLE, arbitration on the registered edge:
  - If both requests are pending, grant IF only if last_owner==DATA; otherwise grant DATA. This alternates on conflict and prevents fetch starvation.
  - If only one request is pending, grant it.
  - If none is pending, stay in IDLE.
  - On grant: latch owner, address with bits [1:0] forced to 0, we (d_we for DATA, 0 for IF) and wdata into mem_addr/mem_we/mem_wdata. Set mem_en=1, cnt=0, go to ACCESS.
  - Increment conflict_cnt when both requests are pending at grant; saturate, no wrap.
- ACCESS:
  - mem_en, mem_we, mem_addr and mem_wdata are held constant for exactly LAT cycles.
  - cnt increments each cycle.
  - When cnt==LAT-1: capture mem_rdata into the owner's rdata register (loads and fetches only; stores leave d_rdata unchanged). Drop mem_en/mem_we, set last_owner=owner, go to DONE.
- DONE:
  - The owner's ready output is 1 for exactly this one cycle.
  - Return to IDLE. No arbitration happens in DONE.
- Latency: request seen in IDLE at edge k gives the ready pulse in cycle k+LAT+1. Back-to-back throughput is one access per LAT+2 cycles.
- Stalls (combinational from registered state and inputs):
  - stall_if = if_req & ~if_ready
  - stall_pipe = d_req & ~d_ready
  - Both may be 1 simultaneously; stall_pipe takes precedence in pipeline control.
- Request dropped mid-access: the access still completes and the ready pulse is still issued. The requester must ignore it. No cancellation.
- Address or data changing while a request is held: ignored after grant, because latched values are used.
- busy = (state != IDLE).
- if_ready and d_ready are never 1 in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with if_req=d_req=1 -> all outputs 0, busy=0. First grant occurs the edge after rst falls.
- Single fetch, LAT=2: if_req=1, if_addr=0x0000_0013, memory returns 0x2001_0005 -> mem_addr=0x0000_0010. mem_en high 2 cycles. if_ready pulses 3 cycles after request with if_rdata=0x2001_0005. stall_if high 3 cycles.
- Store then load: store d_addr=0x40, d_wdata=0xDEAD_BEEF, then load from 0x40 -> mem_we=1 for 2 cycles only on the store. Load d_rdata=0xDEAD_BEEF. d_rdata is unchanged after the store.
- Conflict: if_req and d_req held continuously from reset -> grants alternate DATA, IF, DATA, IF. conflict_cnt counts 1, 2, 3, 4. Ready pulses are 4 cycles apart and never coincide.
- Saturation, CNT_W=4: 20 conflicting grants -> conflict_cnt stops at 15.
- Abort: rst asserted in the second ACCESS cycle of a load -> no d_ready. Next cycle mem_en=0 and state is IDLE.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - two-requester sequencer for a single-ported fixed-latency unified memory
//
// Purpose:
//   Shares one single-ported memory between the instruction-fetch port and the
//   MEM-stage data port. Grants one access at a time, holds the memory
//   interface for LAT cycles, returns read data with a one-cycle ready pulse
//   and produces the fetch/pipeline stall signals.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   if_req/if_addr             fetch request (held until if_ready) and PC
//   if_rdata/if_ready          fetched instruction and completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, store flag, address, store data
//   d_rdata/d_ready            load data and completion pulse
//   stall_if/stall_pipe        freeze PC+IF_to_ID / freeze whole pipeline
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory interface
//   busy                       FSM not idle
//   conflict_cnt               saturating count of grants made with both requests pending

module unified_mem_arbiter #(
   parameter int LAT   = 2,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [31:0]       if_addr,
   output logic [31:0]       if_rdata,
   output logic              if_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic [31:0]       d_rdata,
   output logic              d_ready,
   output logic              stall_if,
   output logic              stall_pipe,
   output logic              mem_en,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF   = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   state_t        state, state_next;
   owner_t        owner, last_owner;
   logic [CW-1:0] cnt;
   logic          grant;
   logic          grant_data;
   logic          conflict;
   logic          access_last;

   assign conflict    = if_req & d_req;
   assign access_last = (cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and arbitration decision
   always_comb begin
      state_next = state;
      grant      = 1'b0;
      grant_data = 1'b0;
      case (state)
         S_IDLE: begin
            if (if_req || d_req) begin
               grant      = 1'b1;
               // On conflict fetch wins only when data owned the previous
               // access, so the two ports alternate and fetch never starves.
               grant_data = d_req && !(if_req && (last_owner == OWN_DATA));
               state_next = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (access_last) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: latched request, access counter, read-data capture
   always_ff @(posedge clk) begin
      if (rst) begin
         owner        <= OWN_IF;
         last_owner   <= OWN_IF;
         cnt          <= '0;
         conflict_cnt <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         if_rdata     <= '0;
         d_rdata      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant) begin
                  owner     <= grant_data ? OWN_DATA : OWN_IF;
                  mem_addr  <= grant_data ? {d_addr[31:2], 2'b00} : {if_addr[31:2], 2'b00};
                  mem_we    <= grant_data & d_we;
                  mem_wdata <= grant_data ? d_wdata : 32'd0;
                  mem_en    <= 1'b1;
                  cnt       <= '0;
                  if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
                     conflict_cnt <= conflict_cnt + 1'b1;
                  end
               end
            end
            S_ACCESS: begin
               cnt <= cnt + 1'b1;
               if (access_last) begin
                  if (owner == OWN_IF) begin
                     if_rdata <= mem_rdata;
                  end else if (!mem_we) begin
                     d_rdata <= mem_rdata;
                  end
                  mem_en     <= 1'b0;
                  mem_we     <= 1'b0;
                  last_owner <= owner;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign if_ready   = (state == S_DONE) && (owner == OWN_IF);
   assign d_ready    = (state == S_DONE) && (owner == OWN_DATA);
   assign busy       = (state != S_IDLE);
   assign stall_if   = if_req & ~if_ready;
   assign stall_pipe = d_req & ~d_ready;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter

module tb_unified_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_ready, d_ready, stall_if, stall_pipe, mem_en, mem_we, busy;
   logic [15:0] conflict_cnt;

   logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
   logic        s_if_ready, s_d_ready, s_stall_if, s_stall_pipe, s_mem_en, s_mem_we, s_busy;
   logic [3:0]  s_conflict_cnt;

   logic [31:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   unified_mem_arbiter #(.LAT(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .stall_if(stall_if), .stall_pipe(stall_pipe),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .conflict_cnt(conflict_cnt)
   );

   unified_mem_arbiter #(.LAT(2), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(s_if_rdata), .if_ready(s_if_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(s_d_rdata), .d_ready(s_d_ready),
      .stall_if(s_stall_if), .stall_pipe(s_stall_pipe),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(mem_rdata), .busy(s_busy), .conflict_cnt(s_conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-addressed memory model driven by the 16-bit-counter instance
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h04] = 32'h2001_0005;   // 0x10
      mem[8'h20] = 32'h1111_2222;   // 0x80

      // Reset with both requests pending
      rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      if_addr = 32'h0000_0010; d_addr = 32'h0000_0080; d_wdata = 32'h0;
      tick; tick;
      check("rst_mem_en",    {31'd0, mem_en},   32'd0);
      check("rst_mem_we",    {31'd0, mem_we},   32'd0);
      check("rst_if_ready",  {31'd0, if_ready}, 32'd0);
      check("rst_d_ready",   {31'd0, d_ready},  32'd0);
      check("rst_busy",      {31'd0, busy},     32'd0);
      check("rst_if_rdata",  if_rdata,          32'd0);
      check("rst_d_rdata",   d_rdata,           32'd0);
      check("rst_mem_addr",  mem_addr,          32'd0);
      check("rst_mem_wdata", mem_wdata,         32'd0);
      check("rst_conflict",  {16'd0, conflict_cnt}, 32'd0);
      rst = 1'b0;

      // Continuous conflict: DATA, IF, DATA, IF ... one grant every 4 cycles
      for (int g = 0; g < 20; g++) begin
         tick;   // grant edge
         check("cf_busy",     {31'd0, busy},   32'd1);
         check("cf_mem_en",   {31'd0, mem_en}, 32'd1);
         check("cf_mem_addr", mem_addr, (g % 2 == 0) ? 32'h80 : 32'h10);
         check("cf_cnt16",    {16'd0, conflict_cnt}, 32'(g + 1));
         check("cf_cnt4_sat", {28'd0, s_conflict_cnt}, (g + 1 > 15) ? 32'd15 : 32'(g + 1));
         tick;
         check("cf_no_ready", {30'd0, if_ready, d_ready}, 32'd0);
         tick;   // DONE
         check("cf_ready", {30'd0, if_ready, d_ready}, (g % 2 == 0) ? 32'd1 : 32'd2);
         if (g % 2 == 0) check("cf_d_rdata",  d_rdata,  32'h1111_2222);
         else            check("cf_if_rdata", if_rdata, 32'h2001_0005);
         tick;   // back in IDLE
         check("cf_idle", {29'd0, busy, if_ready, d_ready}, 32'd0);
      end
      if_req = 1'b0; d_req = 1'b0;
      tick;
      check("cf_stop_busy", {31'd0, busy}, 32'd0);

      // Single fetch from unaligned PC
      if_req = 1'b1; if_addr = 32'h0000_0013;
      #1;
      check("f_stall0", {31'd0, stall_if}, 32'd1);
      tick;
      check("f_mem_addr", mem_addr, 32'h0000_0010);
      check("f_en_we1",  {30'd0, mem_en, mem_we}, 32'd2);
      check("f_stall1", {31'd0, stall_if}, 32'd1);
      if_addr = 32'h0000_0080;   // ignored after grant
      tick;
      check("f_en_we2",  {30'd0, mem_en, mem_we}, 32'd2);
      check("f_stall2", {31'd0, stall_if}, 32'd1);
      check("f_addr_held", mem_addr, 32'h0000_0010);
      tick;
      check("f_ready",  {31'd0, if_ready}, 32'd1);
      check("f_rdata",  if_rdata, 32'h2001_0005);
      check("f_stall3", {31'd0, stall_if}, 32'd0);
      check("f_en_off", {31'd0, mem_en}, 32'd0);
      if_req = 1'b0;
      tick;
      check("f_ready_end", {31'd0, if_ready}, 32'd0);

      // Store 0xDEADBEEF to 0x40
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
      #1;
      check("s_stall_pipe", {31'd0, stall_pipe}, 32'd1);
      tick;
      check("s_en_we1", {30'd0, mem_en, mem_we}, 32'd3);
      check("s_wdata",  mem_wdata, 32'hDEAD_BEEF);
      check("s_addr",   mem_addr,  32'h40);
      tick;
      check("s_en_we2", {30'd0, mem_en, mem_we}, 32'd3);
      tick;
      check("s_ready",    {31'd0, d_ready}, 32'd1);
      check("s_we_off",   {31'd0, mem_we},  32'd0);
      check("s_rdata_kept", d_rdata, 32'h1111_2222);
      check("s_no_stall", {31'd0, stall_pipe}, 32'd0);
      d_req = 1'b0;
      tick;

      // Load back from 0x41 (low bits dropped)
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h41; d_wdata = 32'h0;
      tick;
      check("l_en_we1", {30'd0, mem_en, mem_we}, 32'd2);
      check("l_addr",   mem_addr, 32'h40);
      tick;
      tick;
      check("l_ready", {31'd0, d_ready}, 32'd1);
      check("l_rdata", d_rdata, 32'hDEAD_BEEF);
      d_req = 1'b0;
      tick;

      // Request dropped mid-access still completes
      if_req = 1'b1; if_addr = 32'h10;
      tick;
      if_req = 1'b0;
      tick;
      tick;
      check("drop_ready", {31'd0, if_ready}, 32'd1);
      tick;

      // Reset in second ACCESS cycle of a load aborts it
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      tick;
      tick;
      check("ab_in_access", {30'd0, busy, mem_en}, 32'd3);
      rst = 1'b1;
      tick;
      check("ab_mem_en",  {31'd0, mem_en},  32'd0);
      check("ab_busy",    {31'd0, busy},    32'd0);
      check("ab_d_ready", {31'd0, d_ready}, 32'd0);
      check("ab_d_rdata", d_rdata, 32'd0);
      rst = 1'b0; d_req = 1'b0;
      tick;
      check("ab_no_ready", {30'd0, if_ready, d_ready}, 32'd0);
      check("ab_idle",     {31'd0, busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
